wb_arbiter_rr: RTL

Round-robin Wishbone bus arbiter for the shared-bus interconnect. It grants the single shared slave path (e.g. the wb_spramx32 RAM) to one of NUMM masters, such as the Ibex instruction and data ports. The grant is held for the whole owner cycle (cyc held high), which gives bus-lock semantics. An optional watchdog flags a hung slave.

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_rr_pick.sv | 29 ++
 rtl/wb_arbiter_rr.sv | 133 +++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Width of a binary index into n masters; never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after the last owner,
// searching upward with wrap-around.
module wb_rr_pick
   import wb_arb_pkg::*;
#(
   parameter int NUMM = 2,
   parameter int IW   = idx_width(NUMM)
) (
   input  logic [NUMM-1:0] req,
   input  logic [IW-1:0]   last,
   output logic            valid,
   output logic [IW-1:0]   sel
);

   logic [IW-1:0] cand_s;

   // Scan from the farthest candidate back to last+1 so the nearest requester wins.
   always_comb begin
      valid  = 1'b0;
      sel    = '0;
      cand_s = '0;
      for (int i = NUMM; i >= 1; i--) begin
         cand_s = IW'((int'(last) + i) % NUMM);
         sel    = req[cand_s] ? cand_s : sel;
         valid  = valid | req[cand_s];
      end
   end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone arbiter with bus lock for the whole owner cycle.
// Optional hung-slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_rr
   import wb_arb_pkg::*;
#(
   parameter int NUMM    = 2,
   parameter int TIMEOUT = 255,
   parameter int IW      = idx_width(NUMM)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NUMM-1:0] cyc_i,
   input  logic [NUMM-1:0] stb_i,
   input  logic            ack_i,
   input  logic            err_i,
   output logic [NUMM-1:0] gnt_o,
   output logic [IW-1:0]   gnt_idx_o,
   output logic            busy_o,
   output logic            to_err_o
);

   localparam logic [NUMM-1:0] GNT_ONE   = {{(NUMM-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0]   LAST_INIT = IW'(NUMM-1);

   arb_state_t      state_r, state_s;
   logic [NUMM-1:0] gnt_r, gnt_s;
   logic [IW-1:0]   idx_r, idx_s;
   logic [IW-1:0]   last_r, last_s;
   logic            busy_r;
   logic            pick_valid_s;
   logic [IW-1:0]   pick_sel_s;
   logic            owner_cyc_s;

   wb_rr_pick #(
      .NUMM (NUMM),
      .IW   (IW)
   ) u_pick (
      .req   (cyc_i),
      .last  (last_r),
      .valid (pick_valid_s),
      .sel   (pick_sel_s)
   );

   assign owner_cyc_s = cyc_i[idx_r];

   // Next-state logic: hold while the owner keeps cyc, else hand over or idle.
   always_comb begin
      state_s = state_r;
      gnt_s   = gnt_r;
      idx_s   = idx_r;
      last_s  = last_r;
      case (state_r)
         IDLE: begin
            if (pick_valid_s) begin
               state_s = GRANT;
               gnt_s   = GNT_ONE << pick_sel_s;
               idx_s   = pick_sel_s;
               last_s  = pick_sel_s;
            end else begin
               gnt_s   = '0;
            end
         end
         GRANT: begin
            if (owner_cyc_s) begin
               gnt_s   = gnt_r;
            end else if (pick_valid_s) begin
               gnt_s   = GNT_ONE << pick_sel_s;
               idx_s   = pick_sel_s;
               last_s  = pick_sel_s;
            end else begin
               state_s = IDLE;
               gnt_s   = '0;
            end
         end
         default: begin
            state_s = IDLE;
            gnt_s   = '0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         gnt_r   <= '0;
         idx_r   <= '0;
         last_r  <= LAST_INIT;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         gnt_r   <= gnt_s;
         idx_r   <= idx_s;
         last_r  <= last_s;
         busy_r  <= (state_s == GRANT);
      end
   end

   assign gnt_o     = gnt_r;
   assign gnt_idx_o = idx_r;
   assign busy_o    = busy_r;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] wd_cnt_r;
   logic          wd_stall_s;
   logic          wd_fire_s;
   logic          to_err_r;

   assign wd_stall_s = (state_r == GRANT) && (gnt_s == gnt_r) && owner_cyc_s
                       && stb_i[idx_r] && !ack_i && !err_i;
   assign wd_fire_s  = wd_stall_s && (wd_cnt_r == TW'(TIMEOUT - 1));

   // Stall counter; fires a single-cycle error when the owner's strobe goes unanswered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt_r <= '0;
         to_err_r <= 1'b0;
      end else begin
         wd_cnt_r <= (wd_stall_s && !wd_fire_s) ? (wd_cnt_r + TW'(1)) : '0;
         to_err_r <= wd_fire_s;
      end
   end

   assign to_err_o = to_err_r;
`else
   logic unused_s;
   assign unused_s = ^{stb_i, ack_i, err_i};
   assign to_err_o = 1'b0;
`endif

endmodule
